// File: rtl/exit_fee_collector.sv
// Pay-on-exit transaction controller: latches the fee, takes coins, returns change,
// holds the exit barrier open for a fixed time, accumulates saturating revenue.
module exit_fee_collector #(
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int GATE_OPEN_CYCLES = 50,
  parameter int REV_WIDTH        = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_exit_detected,
  input  logic [7:0]           i_cost,
  input  logic                 i_coin_valid,
  input  logic [3:0]           i_coin_value,
  input  logic                 i_attendant_clear,
  output logic [7:0]           o_amount_due,
  output logic [7:0]           o_change_out,
  output logic                 o_change_valid,
  output logic                 o_coin_reject,
  output logic                 o_gate_open,
  output logic                 o_busy,
  output logic                 o_alarm,
  output logic [REV_WIDTH-1:0] o_revenue
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_ALARM   = 3'd4;

  // One timer serves both the payment timeout and the gate-open interval.
  localparam int TMR_MAX = (TIMEOUT_CYCLES > GATE_OPEN_CYCLES) ? TIMEOUT_CYCLES : GATE_OPEN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [2:0]           r_state;
  logic                 r_pending;
  logic [TMR_W-1:0]     r_timer;
  logic [7:0]           r_fee;
  logic [7:0]           r_amount_due;
  logic [7:0]           r_change_out;
  logic                 r_change_valid;
  logic                 r_coin_reject;
  logic                 r_gate_open;
  logic                 r_alarm;
  logic [REV_WIDTH-1:0] r_revenue;

  logic [2:0]           w_state_next;
  logic                 w_pending_next;
  logic [TMR_W-1:0]     w_timer_next;
  logic [7:0]           w_fee_next;
  logic [7:0]           w_amount_next;
  logic [7:0]           w_change_out_next;
  logic                 w_change_valid_next;
  logic                 w_coin_reject_next;
  logic [REV_WIDTH-1:0] w_revenue_next;

  logic                 w_coin_ok;
  logic [7:0]           w_coin_ext;
  logic [REV_WIDTH:0]   w_rev_sum;
  logic [REV_WIDTH-1:0] w_rev_sat;

  assign w_coin_ok  = i_coin_valid && (i_coin_value != 4'd0);
  assign w_coin_ext = {4'd0, i_coin_value};
  assign w_rev_sum  = {1'b0, r_revenue} + {{(REV_WIDTH + 1 - 8){1'b0}}, r_fee};
  assign w_rev_sat  = w_rev_sum[REV_WIDTH] ? {REV_WIDTH{1'b1}} : w_rev_sum[REV_WIDTH-1:0];

  always_comb begin
    w_state_next        = r_state;
    w_pending_next      = r_pending;
    w_timer_next        = r_timer;
    w_fee_next          = r_fee;
    w_amount_next       = r_amount_due;
    w_change_out_next   = 8'd0;
    w_change_valid_next = 1'b0;
    w_revenue_next      = r_revenue;
    w_coin_reject_next  = i_coin_valid && ((i_coin_value == 4'd0) || (r_state != S_COLLECT));

    // A single exit can wait behind the current transaction; extra ones are lost.
    if (i_exit_detected && (r_state != S_IDLE))
      w_pending_next = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (i_exit_detected || r_pending) begin
          w_state_next   = S_FETCH;
          w_pending_next = 1'b0;
        end
      end
      S_FETCH: begin
        w_fee_next    = i_cost;
        w_amount_next = i_cost;
        w_timer_next  = '0;
        w_state_next  = (i_cost == 8'd0) ? S_OPEN : S_COLLECT;
      end
      S_COLLECT: begin
        if (w_coin_ok) begin
          w_timer_next = '0;
          if (w_coin_ext < r_amount_due) begin
            w_amount_next = r_amount_due - w_coin_ext;
          end else begin
            w_change_out_next   = w_coin_ext - r_amount_due;
            w_change_valid_next = (w_coin_ext != r_amount_due);
            w_amount_next       = 8'd0;
            w_revenue_next      = w_rev_sat;
            w_state_next        = S_OPEN;
          end
        end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = S_ALARM;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_OPEN: begin
        if (r_timer == TMR_W'(GATE_OPEN_CYCLES - 1)) begin
          w_timer_next  = '0;
          w_amount_next = 8'd0;
          w_state_next  = S_IDLE;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_ALARM: begin
        if (i_attendant_clear) begin
          w_amount_next = 8'd0;
          w_timer_next  = '0;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_pending      <= 1'b0;
      r_timer        <= '0;
      r_fee          <= 8'd0;
      r_amount_due   <= 8'd0;
      r_change_out   <= 8'd0;
      r_change_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_gate_open    <= 1'b0;
      r_alarm        <= 1'b0;
      r_revenue      <= '0;
    end else begin
      r_state        <= w_state_next;
      r_pending      <= w_pending_next;
      r_timer        <= w_timer_next;
      r_fee          <= w_fee_next;
      r_amount_due   <= w_amount_next;
      r_change_out   <= w_change_out_next;
      r_change_valid <= w_change_valid_next;
      r_coin_reject  <= w_coin_reject_next;
      r_gate_open    <= (w_state_next == S_OPEN);
      r_alarm        <= (w_state_next == S_ALARM);
      r_revenue      <= w_revenue_next;
    end
  end

  assign o_amount_due   = r_amount_due;
  assign o_change_out   = r_change_out;
  assign o_change_valid = r_change_valid;
  assign o_coin_reject  = r_coin_reject;
  assign o_gate_open    = r_gate_open;
  assign o_busy         = (r_state != S_IDLE);
  assign o_alarm        = r_alarm;
  assign o_revenue      = r_revenue;

endmodule
